// File: rtl/ctrl_pipe_hazard.sv
// ID-stage pre-decoder with EX/MEM/WB control pipeline, load-use/branch hazard
// stalls, IF/ID flush and EX-stage forwarding selects for the 5-stage MIPS core.
module ctrl_pipe_hazard #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_STALL = 1,
  parameter int DELAY_SLOT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [31:0]           id_instr,
  input  logic                  br_taken,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  id_bubble,
  output logic                  ex_rfwr,
  output logic                  mem_rfwr,
  output logic                  wb_rfwr,
  output logic                  ex_load,
  output logic                  mem_load,
  output logic                  mem_dmwr,
  output logic [REG_ADDR_W-1:0] ex_wa,
  output logic [REG_ADDR_W-1:0] mem_wa,
  output logic [REG_ADDR_W-1:0] wb_wa,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  localparam int AW = REG_ADDR_W;
  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL - 1);

  logic [5:0]    op, funct;
  logic [AW-1:0] f_rs, f_rt, f_rd, d_dest, d_wa, d_rs, d_rt;
  logic          d_rfwr, d_load, d_dmwr, use_rs, use_rt, is_br, is_jr, redirect;
  logic          ex_dmwr;
  logic [AW-1:0] ex_rs, ex_rt;
  logic [2:0]    stall_cnt;
  logic          load_use, br_haz, stall;

  assign op    = id_instr[31:26];
  assign funct = id_instr[5:0];
  assign f_rs  = AW'(id_instr[25:21]);
  assign f_rt  = AW'(id_instr[20:16]);
  assign f_rd  = AW'(id_instr[15:11]);

  always_comb begin
    d_rfwr   = 1'b0;
    d_load   = 1'b0;
    d_dmwr   = 1'b0;
    d_dest   = '0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    is_br    = 1'b0;
    is_jr    = 1'b0;
    redirect = 1'b0;
    if (id_valid) begin
      case (op)
        6'h00: begin
          d_dest   = f_rd;
          d_rfwr   = (funct != 6'h08);
          use_rs   = 1'b1;
          use_rt   = 1'b1;
          is_jr    = (funct == 6'h08);
          redirect = (funct == 6'h08) || (funct == 6'h09);
        end
        6'h0D, 6'h0C, 6'h08, 6'h09: begin
          d_dest = f_rt;
          d_rfwr = 1'b1;
          use_rs = 1'b1;
        end
        6'h0F: begin
          d_dest = f_rt;
          d_rfwr = 1'b1;
        end
        6'h23, 6'h20, 6'h24, 6'h21, 6'h25: begin
          d_dest = f_rt;
          d_rfwr = 1'b1;
          d_load = 1'b1;
          use_rs = 1'b1;
        end
        6'h2B, 6'h28, 6'h29: begin
          d_dmwr = 1'b1;
          use_rs = 1'b1;
          use_rt = 1'b1;
        end
        6'h04, 6'h05: begin
          use_rs   = 1'b1;
          use_rt   = 1'b1;
          is_br    = 1'b1;
          redirect = br_taken;
        end
        6'h06, 6'h07, 6'h01: begin
          use_rs   = 1'b1;
          is_br    = 1'b1;
          redirect = br_taken;
        end
        6'h02: redirect = 1'b1;
        6'h03: begin
          d_dest   = AW'(31);
          d_rfwr   = 1'b1;
          redirect = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Unused fields are carried as $0 so they can never match a producer.
  assign d_wa = d_rfwr ? d_dest : '0;
  assign d_rs = use_rs ? f_rs : '0;
  assign d_rt = use_rt ? f_rt : '0;

  function automatic logic hit(input logic [AW-1:0] src, input logic [AW-1:0] wa,
                               input logic rfwr);
    return rfwr && (src != '0) && (src == wa);
  endfunction

  assign load_use = ex_load && (hit(d_rs, ex_wa, ex_rfwr) || hit(d_rt, ex_wa, ex_rfwr));
  assign br_haz   = (is_br || is_jr) &&
                    (hit(d_rs, ex_wa, ex_rfwr) || hit(d_rt, ex_wa, ex_rfwr) ||
                     (mem_load && (hit(d_rs, mem_wa, mem_rfwr) || hit(d_rt, mem_wa, mem_rfwr))));
  assign stall    = load_use || br_haz || (stall_cnt != 3'd0);

  assign pc_en      = mem_ready && !stall;
  assign ifid_en    = mem_ready && !stall;
  assign id_bubble  = mem_ready && stall;
  assign ifid_flush = mem_ready && !stall && (DELAY_SLOT == 0) && redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rfwr   <= 1'b0;
      ex_load   <= 1'b0;
      ex_dmwr   <= 1'b0;
      ex_wa     <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      mem_rfwr  <= 1'b0;
      mem_load  <= 1'b0;
      mem_dmwr  <= 1'b0;
      mem_wa    <= '0;
      wb_rfwr   <= 1'b0;
      wb_wa     <= '0;
      stall_cnt <= 3'd0;
    end else if (mem_ready) begin
      wb_rfwr  <= mem_rfwr;
      wb_wa    <= mem_wa;
      mem_rfwr <= ex_rfwr;
      mem_load <= ex_load;
      mem_dmwr <= ex_dmwr;
      mem_wa   <= ex_wa;
      if (stall) begin
        ex_rfwr <= 1'b0;
        ex_load <= 1'b0;
        ex_dmwr <= 1'b0;
        ex_wa   <= '0;
        ex_rs   <= '0;
        ex_rt   <= '0;
      end else begin
        ex_rfwr <= d_rfwr;
        ex_load <= d_load;
        ex_dmwr <= d_dmwr;
        ex_wa   <= d_wa;
        ex_rs   <= d_rs;
        ex_rt   <= d_rt;
      end
      // The first bubble is the load-use cycle itself; the counter owes the rest.
      if (stall_cnt != 3'd0) stall_cnt <= stall_cnt - 3'd1;
      else if (load_use)     stall_cnt <= STALL_RELOAD;
    end
  end

  // A load in MEM has no result yet, so only a non-load MEM producer forwards.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (hit(ex_rs, mem_wa, mem_rfwr) && !mem_load) fwd_a = 2'b10;
    else if (hit(ex_rs, wb_wa, wb_rfwr))           fwd_a = 2'b01;
    if (hit(ex_rt, mem_wa, mem_rfwr) && !mem_load) fwd_b = 2'b10;
    else if (hit(ex_rt, wb_wa, wb_rfwr))           fwd_b = 2'b01;
  end

endmodule
